// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | imem_loader: fills instruction memory from a length/words/XOR-chk stream |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module imem_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  output logic                         rx_ready,
  output logic                         we,
  output logic [AW-1:0]                waddr,
  output logic [31:0]                  wdata,
  output logic                         cpu_reset,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   word_cnt
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_BYTES = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]    lane_q, lane_d;
  logic [7:0]    chk_q, chk_d;
  logic [31:0]   wdata_q, wdata_d;

  logic          w_accept;
  logic          w_len_ok;
  logic [CW-1:0] w_idx_nxt;

  // Handshake is decoded purely from state so rx_valid never reaches rx_ready.
  assign rx_ready  = (state_q == S_LEN) || (state_q == S_BYTES) || (state_q == S_CHK);
  assign w_accept  = rx_valid && rx_ready;
  assign w_len_ok  = ({24'd0, rx_data} <= 32'(DEPTH));
  assign w_idx_nxt = CW'(idx_q) + CW'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    lane_d     = lane_q;
    chk_d      = chk_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN;
          idx_d      = '0;
          n_d        = '0;
          word_cnt_d = '0;
          lane_d     = '0;
          chk_d      = '0;
        end
      end
      S_LEN: begin
        if (w_accept) begin
          if (rx_data == 8'd0) begin
            state_d = S_CHK;
          end else if (!w_len_ok) begin
            state_d = S_ERR;
          end else begin
            n_d     = CW'(rx_data);
            state_d = S_BYTES;
          end
        end
      end
      S_BYTES: begin
        if (w_accept) begin
          wdata_d[8*lane_q +: 8] = rx_data;
          chk_d  = chk_q ^ rx_data;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        idx_d      = idx_q + IW'(1);
        word_cnt_d = word_cnt_q + CW'(1);
        lane_d     = '0;
        state_d    = (w_idx_nxt == n_q) ? S_CHK : S_BYTES;
      end
      S_CHK: begin
        if (w_accept) begin
          state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      word_cnt_q <= '0;
      lane_q     <= '0;
      chk_q      <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      lane_q     <= lane_d;
      chk_q      <= chk_d;
      wdata_q    <= wdata_d;
    end
  end

  assign we        = (state_q == S_WRITE);
  assign waddr     = AW'({idx_q, 2'b00});
  assign wdata     = wdata_q;
  assign cpu_reset = (state_q != S_DONE);
  assign busy      = (state_q == S_LEN) || (state_q == S_BYTES) ||
                     (state_q == S_WRITE) || (state_q == S_CHK);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign word_cnt  = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_imem_loader: directed self-checking bench for imem_loader             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_imem_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset, start, rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready, we, cpu_reset, busy, done, err;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic [CW-1:0] word_cnt;

  int tests = 0;
  int fails = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .we(we), .waddr(waddr),
    .wdata(wdata), .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
    end
  end

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #12;
    @(negedge clk);
    reset = 1'b0;
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // gap = idle cycles with rx_valid low before offering the byte
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'hA5;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL send_byte_timeout: byte %h not accepted, rx_ready=%b required 1", b, rx_ready);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 20) begin
      fails++;
      $display("FAIL wait_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic send_nominal(input logic [7:0] chk, input int gap, input bit stray);
    logic [7:0] bytes [8];
    bytes = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
    send_byte(8'h02, gap);
    for (int i = 0; i < 8; i++) begin
      send_byte(bytes[i], gap);
      if (stray && (i == 1 || i == 3)) pulse_start();
    end
    send_byte(chk, gap);
    wait_idle();
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({rx_ready, we, busy, done, err, cpu_reset} !== 6'b000001) begin
      fails++;
      $display("FAIL reset_flags: got %b required 000001", {rx_ready, we, busy, done, err, cpu_reset});
    end
    tests++;
    if (waddr !== '0 || wdata !== '0 || word_cnt !== '0) begin
      fails++;
      $display("FAIL reset_values: waddr=%h wdata=%h word_cnt=%0d required 0", waddr, wdata, word_cnt);
    end
  endtask

  task automatic test_reset_mid_load();
    apply_reset();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h13, 0);
    send_byte(8'h01, 0);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({rx_ready, we, busy, done, err, cpu_reset} !== 6'b000001 ||
        waddr !== '0 || wdata !== '0 || word_cnt !== '0) begin
      fails++;
      $display("FAIL midload_reset: flags=%b waddr=%h wdata=%h cnt=%0d required 000001/0/0/0",
               {rx_ready, we, busy, done, err, cpu_reset}, waddr, wdata, word_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (wa_q.size() != 0) begin
      fails++;
      $display("FAIL midload_no_we: got %0d writes required 0", wa_q.size());
    end
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h13, 0); send_byte(8'h01, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
    send_byte(8'h42, 0);
    wait_idle();
    tests++;
    if (wa_q.size() != 1 || wa_q[0] !== 32'h0 || wd_q[0] !== 32'h00500113) begin
      fails++;
      $display("FAIL one_word_write: n=%0d addr=%h data=%h required 1/0/00500113",
               wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : 32'hx, (wd_q.size() > 0) ? wd_q[0] : 32'hx);
    end
    tests++;
    if (done !== 1'b1 || err !== 1'b0 || cpu_reset !== 1'b0 || word_cnt !== CW'(1)) begin
      fails++;
      $display("FAIL one_word_status: done=%b err=%b cpu_reset=%b cnt=%0d required 1/0/0/1",
               done, err, cpu_reset, word_cnt);
    end
  endtask

  task automatic test_nominal();
    apply_reset();
    pulse_start();
    send_nominal(8'h10, 0, 1'b0);
    tests++;
    if (wa_q.size() != 2 || wa_q[0] !== 32'h0 || wd_q[0] !== 32'h00500113 ||
        wa_q[1] !== 32'h4 || wd_q[1] !== 32'h00C00193) begin
      fails++;
      $display("FAIL nominal_writes: n=%0d required 2 at 0:00500113 4:00C00193", wa_q.size());
    end
    tests++;
    if (word_cnt !== CW'(2) || done !== 1'b1 || err !== 1'b0 || cpu_reset !== 1'b0) begin
      fails++;
      $display("FAIL nominal_status: cnt=%0d done=%b err=%b cpu_reset=%b required 2/1/0/0",
               word_cnt, done, err, cpu_reset);
    end
    // rx_valid while DONE must not consume bytes or disturb status
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h77;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    tests++;
    if (rx_ready !== 1'b0 || done !== 1'b1 || word_cnt !== CW'(2)) begin
      fails++;
      $display("FAIL done_rx_ignored: rx_ready=%b done=%b cnt=%0d required 0/1/2", rx_ready, done, word_cnt);
    end
    pulse_start();
    tests++;
    if (cpu_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || word_cnt !== '0) begin
      fails++;
      $display("FAIL restart_from_done: cpu_reset=%b done=%b busy=%b cnt=%0d required 1/0/1/0",
               cpu_reset, done, busy, word_cnt);
    end
  endtask

  task automatic test_bad_checksum();
    apply_reset();
    pulse_start();
    send_nominal(8'h11, 0, 1'b0);
    tests++;
    if (wa_q.size() != 2 || wd_q[0] !== 32'h00500113 || wd_q[1] !== 32'h00C00193) begin
      fails++;
      $display("FAIL badchk_writes: n=%0d required 2 writes", wa_q.size());
    end
    tests++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1) begin
      fails++;
      $display("FAIL badchk_status: err=%b done=%b cpu_reset=%b required 1/0/1", err, done, cpu_reset);
    end
  endtask

  task automatic test_length_bounds();
    apply_reset();
    pulse_start();
    send_byte(8'h21, 0);
    wait_idle();
    tests++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_reset !== 1'b1 || wa_q.size() != 0) begin
      fails++;
      $display("FAIL badlen: err=%b done=%b cpu_reset=%b writes=%0d required 1/0/1/0",
               err, done, cpu_reset, wa_q.size());
    end
    pulse_start();
    tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_from_err: err=%b busy=%b required 0/1", err, busy);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    wait_idle();
    tests++;
    if (done !== 1'b1 || err !== 1'b0 || word_cnt !== '0 || wa_q.size() != 0) begin
      fails++;
      $display("FAIL empty_image: done=%b err=%b cnt=%0d writes=%0d required 1/0/0/0",
               done, err, word_cnt, wa_q.size());
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    pulse_start();
    send_nominal(8'h10, 2, 1'b1);
    tests++;
    if (wa_q.size() != 2 || wa_q[0] !== 32'h0 || wd_q[0] !== 32'h00500113 ||
        wa_q[1] !== 32'h4 || wd_q[1] !== 32'h00C00193) begin
      fails++;
      $display("FAIL gapped_writes: n=%0d required 2 at 0:00500113 4:00C00193", wa_q.size());
    end
    tests++;
    if (done !== 1'b1 || word_cnt !== CW'(2) || cpu_reset !== 1'b0) begin
      fails++;
      $display("FAIL gapped_status: done=%b cnt=%0d cpu_reset=%b required 1/2/0", done, word_cnt, cpu_reset);
    end
  endtask

  task automatic test_full_depth();
    int bad;
    logic [7:0] wb [4];
    wb = '{8'h63, 8'h00, 8'h21, 8'h00};
    apply_reset();
    pulse_start();
    send_byte(8'h20, 0);
    for (int w = 0; w < DEPTH; w++)
      for (int b = 0; b < 4; b++) send_byte(wb[b], 0);
    send_byte(8'h00, 0);
    wait_idle();
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++)
      if (wa_q[i] !== 32'(i * 4) || wd_q[i] !== 32'h00210063) bad++;
    tests++;
    if (wa_q.size() != DEPTH || bad != 0) begin
      fails++;
      $display("FAIL full_writes: n=%0d bad=%0d required %0d/0", wa_q.size(), bad, DEPTH);
    end
    tests++;
    if (wa_q.size() == 0 || wa_q[wa_q.size()-1] !== 32'h7C) begin
      fails++;
      $display("FAIL full_last_addr: got %h required 0000007c",
               (wa_q.size() > 0) ? wa_q[wa_q.size()-1] : 32'hx);
    end
    tests++;
    if (done !== 1'b1 || word_cnt !== CW'(DEPTH)) begin
      fails++;
      $display("FAIL full_status: done=%b cnt=%0d required 1/%0d", done, word_cnt, DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_nominal();
    test_bad_checksum();
    test_length_bounds();
    test_back_to_back();
    test_full_depth();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
